// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIN  = 2'b10
  } state_e;

  function automatic logic op_is_div(op_e o);
    return (o == OP_DIVU) || (o == OP_DIV);
  endfunction

  function automatic logic op_is_signed(op_e o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle.
// Works on operand magnitudes; signs are applied when leaving CALC.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             we
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e                 r_state;
  op_e                    r_op;
  logic [CNT_W-1:0]       r_cnt;
  logic [WIDTH-1:0]       r_a;
  logic [WIDTH-1:0]       r_b;
  logic [2*WIDTH-1:0]     r_acc;
  logic [WIDTH-1:0]       r_hi;
  logic [WIDTH-1:0]       r_lo;
  logic                   r_we;

  op_e                    w_op_in;
  logic [WIDTH-1:0]       w_ma_in;
  logic [WIDTH-1:0]       w_mb_in;
  logic [WIDTH-1:0]       w_load;
  logic                   w_sa;
  logic                   w_sb;
  logic [WIDTH-1:0]       w_ma;
  logic [WIDTH-1:0]       w_mb;
  logic [WIDTH:0]         w_madd;
  logic [2*WIDTH-1:0]     w_mul_next;
  logic [WIDTH:0]         w_part;
  logic [WIDTH:0]         w_diff;
  logic                   w_ge;
  logic [WIDTH-1:0]       w_rem_new;
  logic [2*WIDTH-1:0]     w_div_next;
  logic [2*WIDTH-1:0]     w_prod;
  logic [WIDTH-1:0]       w_q;
  logic [WIDTH-1:0]       w_r;
  logic [WIDTH-1:0]       w_fin_hi;
  logic [WIDTH-1:0]       w_fin_lo;

  // Operand magnitudes at the accepting edge (from ports) and during CALC (from captured copies)
  always_comb begin
    w_op_in = op_e'(op);
    w_ma_in = (op_is_signed(w_op_in) && a[WIDTH-1]) ? -a : a;
    w_mb_in = (op_is_signed(w_op_in) && b[WIDTH-1]) ? -b : b;
    // Multiply shifts the multiplier out of the low half; divide shifts the dividend
    w_load  = op_is_div(w_op_in) ? w_ma_in : w_mb_in;
    w_sa    = op_is_signed(r_op) && r_a[WIDTH-1];
    w_sb    = op_is_signed(r_op) && r_b[WIDTH-1];
    w_ma    = w_sa ? -r_a : r_a;
    w_mb    = w_sb ? -r_b : r_b;
  end

  // One iteration step for each algorithm
  always_comb begin
    w_madd     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? w_ma : '0)};
    w_mul_next = {w_madd, r_acc[WIDTH-1:1]};
    w_part     = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    w_diff     = w_part - {1'b0, w_mb};
    w_ge       = (w_part >= {1'b0, w_mb});
    w_rem_new  = w_ge ? w_diff[WIDTH-1:0] : w_part[WIDTH-1:0];
    w_div_next = {w_rem_new, r_acc[WIDTH-2:0], w_ge};
  end

  // Sign correction and divide-by-zero override applied on the write-back edge
  always_comb begin
    w_prod = ((r_op == OP_MULT) && (r_a[WIDTH-1] ^ r_b[WIDTH-1])) ? -r_acc : r_acc;
    w_q    = r_acc[WIDTH-1:0];
    w_r    = r_acc[2*WIDTH-1:WIDTH];
    if (r_op == OP_DIV) begin
      if (w_sa ^ w_sb) w_q = -w_q;
      if (w_sa)        w_r = -w_r;
    end
    if (op_is_div(r_op)) begin
      if (r_b == '0) begin
        w_fin_hi = r_a;
        w_fin_lo = '1;
      end else begin
        w_fin_hi = w_r;
        w_fin_lo = w_q;
      end
    end else begin
      w_fin_hi = w_prod[2*WIDTH-1:WIDTH];
      w_fin_lo = w_prod[WIDTH-1:0];
    end
  end

  // Control FSM, operand capture, iteration datapath and registered HI/LO write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_op    <= OP_MULTU;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_we    <= 1'b0;
    end else begin
      r_we <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_op    <= w_op_in;
            r_a     <= a;
            r_b     <= b;
            r_acc   <= {{WIDTH{1'b0}}, w_load};
            r_cnt   <= '0;
            r_state <= CALC;
          end
        end
        CALC: begin
          r_acc <= op_is_div(r_op) ? w_div_next : w_mul_next;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST) r_state <= FIN;
        end
        FIN: begin
          r_hi    <= w_fin_hi;
          r_lo    <= w_fin_lo;
          r_we    <= 1'b1;
          r_cnt   <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = (r_state != IDLE);
  assign hi   = r_hi;
  assign lo   = r_lo;
  assign we   = r_we;

endmodule
